// File: rtl/mc_sequencer.sv
// mc_sequencer: multicycle control sequencer for the non-pipelined CPU datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB/MD_WAIT, decodes the
// register and memory strobes from the current state plus handshake inputs,
// and owns the memory-wait watchdog and the cycle/retired-instruction counters.
module mc_sequencer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  op_class,
    input  logic        is_link,
    input  logic        branch_taken,
    input  logic        mem_ready,
    input  logic        md_done,
    output logic        pc_write,
    output logic        ir_write,
    output logic        a_write,
    output logic        b_write,
    output logic        alu_out_write,
    output logic        mdr_write,
    output logic        hilo_write,
    output logic        rf_write,
    output logic [1:0]  pc_src,
    output logic [1:0]  rf_src,
    output logic        mem_read,
    output logic        mem_write,
    output logic        md_start,
    output logic [2:0]  state,
    output logic        instr_done,
    output logic        halted,
    output logic        bus_err,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXEC    = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_MD_WAIT = 3'd5,
        S_HALT    = 3'd7
    } state_t;

    localparam logic [2:0] C_ALU_R  = 3'd0;
    localparam logic [2:0] C_ALU_I  = 3'd1;
    localparam logic [2:0] C_LOAD   = 3'd2;
    localparam logic [2:0] C_STORE  = 3'd3;
    localparam logic [2:0] C_BRANCH = 3'd4;
    localparam logic [2:0] C_JUMP   = 3'd5;
    localparam logic [2:0] C_MULDIV = 3'd6;
    localparam logic [2:0] C_HALT   = 3'd7;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    localparam logic [1:0] RF_ALU  = 2'd0;
    localparam logic [1:0] RF_MDR  = 2'd1;
    localparam logic [1:0] RF_LINK = 2'd2;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t     cur;
    state_t     nxt;
    logic [7:0] wait_cnt;
    logic       mem_phase;
    logic       timeout;

    assign state = cur;

    // Watchdog condition: memory has stalled too long in a memory-access state.
    // mem_ready takes priority, so a completion on the limit cycle still proceeds.
    always_comb begin
        mem_phase = (cur == S_FETCH) || (cur == S_MEM);
        timeout   = mem_phase && !mem_ready && (wait_cnt == TIMEOUT_CNT);
    end

    // Next-state and strobe decode; everything is forced low while in reset.
    always_comb begin
        nxt           = cur;
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        a_write       = 1'b0;
        b_write       = 1'b0;
        alu_out_write = 1'b0;
        mdr_write     = 1'b0;
        hilo_write    = 1'b0;
        rf_write      = 1'b0;
        pc_src        = PC_PLUS4;
        rf_src        = RF_ALU;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        md_start      = 1'b0;
        instr_done    = 1'b0;
        if (rst) begin
            nxt = S_FETCH;
        end else begin
            case (cur)
                S_FETCH: begin
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        nxt      = S_DECODE;
                    end else if (timeout) begin
                        nxt = S_HALT;
                    end
                end
                S_DECODE: begin
                    a_write = 1'b1;
                    b_write = 1'b1;
                    nxt     = (op_class == C_HALT) ? S_HALT : S_EXEC;
                end
                S_EXEC: begin
                    case (op_class)
                        C_ALU_R, C_ALU_I: begin
                            alu_out_write = 1'b1;
                            nxt           = S_WB;
                        end
                        C_LOAD, C_STORE: begin
                            alu_out_write = 1'b1;
                            nxt           = S_MEM;
                        end
                        C_BRANCH: begin
                            pc_src     = PC_BRANCH;
                            pc_write   = branch_taken;
                            instr_done = 1'b1;
                            nxt        = S_FETCH;
                        end
                        C_JUMP: begin
                            pc_write = 1'b1;
                            pc_src   = PC_JUMP;
                            if (is_link) begin
                                nxt = S_WB;
                            end else begin
                                instr_done = 1'b1;
                                nxt        = S_FETCH;
                            end
                        end
                        C_MULDIV: begin
                            md_start = 1'b1;
                            nxt      = S_MD_WAIT;
                        end
                        default: begin
                            nxt = S_HALT;
                        end
                    endcase
                end
                S_MEM: begin
                    if (op_class == C_LOAD) begin
                        mem_read = 1'b1;
                    end else begin
                        mem_write = 1'b1;
                    end
                    if (mem_ready) begin
                        if (op_class == C_LOAD) begin
                            mdr_write = 1'b1;
                            nxt       = S_WB;
                        end else begin
                            instr_done = 1'b1;
                            nxt        = S_FETCH;
                        end
                    end else if (timeout) begin
                        nxt = S_HALT;
                    end
                end
                S_WB: begin
                    rf_write   = 1'b1;
                    instr_done = 1'b1;
                    if (op_class == C_LOAD) begin
                        rf_src = RF_MDR;
                    end else if (op_class == C_JUMP) begin
                        rf_src = RF_LINK;
                    end else begin
                        rf_src = RF_ALU;
                    end
                    nxt = S_FETCH;
                end
                S_MD_WAIT: begin
                    if (md_done) begin
                        hilo_write = 1'b1;
                        instr_done = 1'b1;
                        nxt        = S_FETCH;
                    end
                end
                S_HALT: begin
                    nxt = S_HALT;
                end
                default: begin
                    nxt = S_FETCH;
                end
            endcase
        end
    end

    // State register plus sticky halt/bus-error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur     <= S_FETCH;
            halted  <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            cur <= nxt;
            if (nxt == S_HALT) begin
                halted <= 1'b1;
            end
            if (timeout) begin
                bus_err <= 1'b1;
            end
        end
    end

    // Wait counter: counts stalled FETCH/MEM cycles, cleared on ready or state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (mem_phase && !mem_ready && (nxt == cur)) begin
            wait_cnt <= wait_cnt + 8'd1;
        end else begin
            wait_cnt <= '0;
        end
    end

    // Free-running cycle and retired-instruction counters; cycles freeze in HALT.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (cur != S_HALT) begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
            if (instr_done) begin
                instret_cnt <= instret_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_mc_sequencer.sv
// Testbench for mc_sequencer: expands each instruction into its expected
// per-cycle state/strobe trace from the class timing rules, drives the
// handshakes from that trace (random values where they must be ignored),
// and compares every cycle, plus directed reset/timeout/halt scenarios.
module tb_mc_sequencer;

    localparam logic [2:0] ST_F = 3'd0;
    localparam logic [2:0] ST_D = 3'd1;
    localparam logic [2:0] ST_E = 3'd2;
    localparam logic [2:0] ST_M = 3'd3;
    localparam logic [2:0] ST_W = 3'd4;
    localparam logic [2:0] ST_Q = 3'd5;
    localparam logic [2:0] ST_H = 3'd7;

    localparam logic [15:0] O_PCW  = 16'h8000;
    localparam logic [15:0] O_IRW  = 16'h4000;
    localparam logic [15:0] O_AW   = 16'h2000;
    localparam logic [15:0] O_BW   = 16'h1000;
    localparam logic [15:0] O_ALU  = 16'h0800;
    localparam logic [15:0] O_MDR  = 16'h0400;
    localparam logic [15:0] O_HILO = 16'h0200;
    localparam logic [15:0] O_RFW  = 16'h0100;
    localparam logic [15:0] O_MRD  = 16'h0080;
    localparam logic [15:0] O_MWR  = 16'h0040;
    localparam logic [15:0] O_MDS  = 16'h0020;
    localparam logic [15:0] O_DONE = 16'h0010;
    localparam logic [15:0] O_PCBR = 16'h0004;
    localparam logic [15:0] O_PCJ  = 16'h0008;
    localparam logic [15:0] O_RMDR = 16'h0001;
    localparam logic [15:0] O_RPC  = 16'h0002;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  op_class = '0;
    logic        is_link = 1'b0;
    logic        branch_taken = 1'b0;
    logic        mem_ready = 1'b0;
    logic        md_done = 1'b0;
    logic        pc_write, ir_write, a_write, b_write, alu_out_write, mdr_write;
    logic        hilo_write, rf_write, mem_read, mem_write, md_start, instr_done;
    logic [1:0]  pc_src, rf_src;
    logic [2:0]  state;
    logic        halted, bus_err;
    logic [31:0] cycle_cnt, instret_cnt;
    logic [15:0] obs;

    mc_sequencer #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .op_class(op_class), .is_link(is_link),
        .branch_taken(branch_taken), .mem_ready(mem_ready), .md_done(md_done),
        .pc_write(pc_write), .ir_write(ir_write), .a_write(a_write), .b_write(b_write),
        .alu_out_write(alu_out_write), .mdr_write(mdr_write), .hilo_write(hilo_write),
        .rf_write(rf_write), .pc_src(pc_src), .rf_src(rf_src), .mem_read(mem_read),
        .mem_write(mem_write), .md_start(md_start), .state(state),
        .instr_done(instr_done), .halted(halted), .bus_err(bus_err),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    assign obs = {pc_write, ir_write, a_write, b_write, alu_out_write, mdr_write,
                  hilo_write, rf_write, mem_read, mem_write, md_start, instr_done,
                  pc_src, rf_src};

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  st;
        logic [15:0] outs;
        logic [2:0]  cls;
        logic        lnk;
        logic        mr;
        logic        md;
        logic        bt;
        logic        hlt;
        logic        berr;
    } cyc_t;

    cyc_t        plan[$];
    int unsigned n_chk = 0;
    int unsigned n_pass = 0;
    int unsigned exp_cyc = 0;
    int unsigned exp_ret = 0;
    logic [2:0]  cur_cls = '0;
    logic        cur_lnk = 1'b0;
    logic        cur_hlt = 1'b0;
    logic        cur_berr = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    task automatic push(input logic [2:0] st, input logic [15:0] outs,
                        input logic mr, input logic md, input logic bt);
        cyc_t e;
        e.st   = st;
        e.outs = outs;
        e.mr   = mr;
        e.md   = md;
        e.bt   = bt;
        e.hlt  = cur_hlt;
        e.berr = cur_berr;
        if (st == ST_F || st == ST_H) begin
            e.cls = 3'($urandom);
            e.lnk = rb();
        end else begin
            e.cls = cur_cls;
            e.lnk = cur_lnk;
        end
        plan.push_back(e);
    endtask

    // One instruction: fw stalled fetch cycles, mw stalled memory cycles,
    // n MD_WAIT cycles before md_done, md_ex = md_done level during md_start.
    task automatic gen_instr(input logic [2:0] cls, input logic lnk, input logic bt,
                             input int fw, input int mw, input int n, input logic md_ex);
        cur_cls = cls;
        cur_lnk = lnk;
        for (int i = 0; i < fw; i++) push(ST_F, O_MRD, 1'b0, rb(), rb());
        push(ST_F, O_MRD | O_IRW | O_PCW, 1'b1, rb(), rb());
        push(ST_D, O_AW | O_BW, rb(), rb(), rb());
        case (cls)
            3'd0, 3'd1: begin
                push(ST_E, O_ALU, rb(), rb(), rb());
                push(ST_W, O_RFW | O_DONE, rb(), rb(), rb());
            end
            3'd2: begin
                push(ST_E, O_ALU, rb(), rb(), rb());
                for (int i = 0; i < mw; i++) push(ST_M, O_MRD, 1'b0, rb(), rb());
                push(ST_M, O_MRD | O_MDR, 1'b1, rb(), rb());
                push(ST_W, O_RFW | O_DONE | O_RMDR, rb(), rb(), rb());
            end
            3'd3: begin
                push(ST_E, O_ALU, rb(), rb(), rb());
                for (int i = 0; i < mw; i++) push(ST_M, O_MWR, 1'b0, rb(), rb());
                push(ST_M, O_MWR | O_DONE, 1'b1, rb(), rb());
            end
            3'd4: begin
                push(ST_E, O_PCBR | O_DONE | (bt ? O_PCW : 16'h0), rb(), rb(), bt);
            end
            3'd5: begin
                push(ST_E, O_PCW | O_PCJ | (lnk ? 16'h0 : O_DONE), rb(), rb(), rb());
                if (lnk) push(ST_W, O_RFW | O_DONE | O_RPC, rb(), rb(), rb());
            end
            3'd6: begin
                push(ST_E, O_MDS, rb(), md_ex, rb());
                for (int i = 0; i < n; i++) push(ST_Q, 16'h0, rb(), 1'b0, rb());
                push(ST_Q, O_HILO | O_DONE, rb(), 1'b1, rb());
            end
            default: begin
                cur_hlt = 1'b1;
                repeat (3) push(ST_H, 16'h0, rb(), rb(), rb());
            end
        endcase
    endtask

    // Entered and left at 1 time unit after a rising edge.
    task automatic run_plan();
        cyc_t e;
        while (plan.size() > 0) begin
            e = plan.pop_front();
            op_class     = e.cls;
            is_link      = e.lnk;
            mem_ready    = e.mr;
            md_done      = e.md;
            branch_taken = e.bt;
            @(negedge clk);
            check("state", 32'(state), 32'(e.st));
            check("strobes", 32'(obs), 32'(e.outs));
            check("cycle_cnt", cycle_cnt, exp_cyc);
            check("instret_cnt", instret_cnt, exp_ret);
            check("halted", 32'(halted), 32'(e.hlt));
            check("bus_err", 32'(bus_err), 32'(e.berr));
            if (e.st != ST_H) exp_cyc++;
            if (e.outs[4]) exp_ret++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        mem_ready    = 1'b1;
        md_done      = 1'b1;
        branch_taken = 1'b1;
        op_class     = 3'd2;
        @(negedge clk);
        check("rst_strobes", 32'(obs), 32'h0);
        check("rst_mem_write", 32'(mem_write), 32'h0);
        check("rst_instr_done", 32'(instr_done), 32'h0);
        @(posedge clk);
        #1;
        check("rst_state", 32'(state), 32'(ST_F));
        check("rst_cycle_cnt", cycle_cnt, 32'h0);
        check("rst_instret_cnt", instret_cnt, 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_bus_err", 32'(bus_err), 32'h0);
        rst      = 1'b0;
        exp_cyc  = 0;
        exp_ret  = 0;
        cur_hlt  = 1'b0;
        cur_berr = 1'b0;
    endtask

    initial begin
        do_reset();

        // Back-to-back ALU_R with memory always ready.
        repeat (3) gen_instr(3'd0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
        run_plan();
        check("instret_after_12", instret_cnt, 32'd3);

        // LOAD with three stalled MEM cycles.
        gen_instr(3'd2, 1'b0, 1'b0, 0, 3, 0, 1'b0);
        // BRANCH not taken, then taken.
        gen_instr(3'd4, 1'b0, 1'b0, 0, 0, 0, 1'b0);
        gen_instr(3'd4, 1'b0, 1'b1, 0, 0, 0, 1'b0);
        // MULDIV with early md_done during md_start, real one later.
        gen_instr(3'd6, 1'b0, 1'b0, 0, 0, 5, 1'b1);
        // JUMP with and without link.
        gen_instr(3'd5, 1'b1, 1'b0, 0, 0, 0, 1'b0);
        gen_instr(3'd5, 1'b0, 1'b0, 0, 0, 0, 1'b0);
        // Ready arriving exactly on the timeout cycle still completes.
        gen_instr(3'd3, 1'b0, 1'b0, 4, 4, 0, 1'b0);
        run_plan();

        // HALT instruction: no instr_done, halted, counters frozen.
        gen_instr(3'd7, 1'b0, 1'b0, 0, 0, 0, 1'b0);
        run_plan();
        do_reset();

        // STORE interrupted by reset while stalled in MEM.
        cur_cls = 3'd3;
        cur_lnk = 1'b0;
        push(ST_F, O_MRD | O_IRW | O_PCW, 1'b1, 1'b0, 1'b0);
        push(ST_D, O_AW | O_BW, 1'b0, 1'b0, 1'b0);
        push(ST_E, O_ALU, 1'b0, 1'b0, 1'b0);
        push(ST_M, O_MWR, 1'b0, 1'b0, 1'b0);
        run_plan();
        check("mid_store_state", 32'(state), 32'(ST_M));
        do_reset();

        // Watchdog in FETCH.
        repeat (5) push(ST_F, O_MRD, 1'b0, rb(), rb());
        cur_hlt  = 1'b1;
        cur_berr = 1'b1;
        repeat (3) push(ST_H, 16'h0, rb(), rb(), rb());
        run_plan();
        do_reset();

        // Watchdog in MEM during a LOAD.
        cur_cls = 3'd2;
        push(ST_F, O_MRD | O_IRW | O_PCW, 1'b1, 1'b0, 1'b0);
        push(ST_D, O_AW | O_BW, 1'b1, 1'b0, 1'b0);
        push(ST_E, O_ALU, 1'b1, 1'b0, 1'b0);
        repeat (5) push(ST_M, O_MRD, 1'b0, rb(), rb());
        cur_hlt  = 1'b1;
        cur_berr = 1'b1;
        repeat (3) push(ST_H, 16'h0, rb(), rb(), rb());
        run_plan();
        do_reset();

        // Random instruction stream.
        for (int k = 0; k < 250; k++) begin
            gen_instr(3'($urandom_range(0, 6)), rb(), rb(),
                      int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                      int'($urandom_range(0, 6)), rb());
            run_plan();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
